// File: rtl/output_send_sched.sv
// rtl/output_send_sched.sv - queues write-back requests and sequences OUTPUT_SEND/OUTPUT_SEND_POOL handshakes
// Optional macro OUTPUT_SEND_SCHED_PERF_EN adds PERF_STALL/PERF_ACTIVE counters.
module output_send_sched #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RSTL,
  input  logic        LAYER_START,
  input  logic [15:0] BASE_ADDR,
  input  logic [15:0] ADDR_STRIDE,
  input  logic        REQ_VALID,
  input  logic        REQ_POOL,
  input  logic [5:0]  REQ_CTRL,
  input  logic [7:0]  REQ_COUNT,
  output logic        REQ_READY,
  input  logic        OUTPUT_BUSY,
  output logic        OUTPUT_SEND,
  output logic        OUTPUT_SEND_POOL,
  output logic [7:0]  COUNTER0,
  output logic [15:0] WADDRX_I,
  output logic [5:0]  OUTPUT_EN_CTRL_I,
  output logic        SCHED_BUSY,
  output logic [7:0]  DONE_CNT,
  output logic        ERR
`ifdef OUTPUT_SEND_SCHED_PERF_EN
  ,
  output logic [15:0] PERF_STALL,
  output logic [15:0] PERF_ACTIVE
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_ADVANCE
  } state_t;

  state_t        state_q;
  logic [14:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q;
  logic          push, pop, layer_ok;
  logic [14:0]   head;

  logic          send_q, send_pool_q;
  logic [7:0]    count0_q;
  logic [15:0]   waddr_q, addr_q;
  logic [5:0]    ctrl_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    done_q;
  logic          err_q;

  assign push     = REQ_VALID && ready_q;
  assign pop      = (state_q == S_IDLE) && (count_q != '0);
  assign head     = mem_q[rd_ptr_q];
  assign layer_ok = (state_q == S_IDLE) && (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (!push && pop)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem_q[wr_ptr_q] <= {REQ_POOL, REQ_CTRL, REQ_COUNT};
  end

  // READY is registered so it stays low through reset and a same-cycle pop only frees a slot next cycle
  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ready_q <= (count_d < CW'(DEPTH));
    end
  end

  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) begin
      state_q     <= S_IDLE;
      send_q      <= 1'b0;
      send_pool_q <= 1'b0;
      count0_q    <= '0;
      waddr_q     <= '0;
      ctrl_q      <= '0;
      addr_q      <= '0;
      tmo_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      send_q      <= 1'b0;
      send_pool_q <= 1'b0;
      if (LAYER_START) begin
        if (layer_ok) begin
          addr_q <= BASE_ADDR;
          done_q <= '0;
        end else begin
          err_q <= 1'b1;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            count0_q    <= head[7:0];
            ctrl_q      <= head[13:8];
            waddr_q     <= addr_q;
            send_q      <= !head[14];
            send_pool_q <= head[14];
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_q   <= '0;
          state_q <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (OUTPUT_BUSY) begin
            state_q <= S_WAIT_DONE;
          end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!OUTPUT_BUSY) state_q <= S_ADVANCE;
        end
        S_ADVANCE: begin
          addr_q <= addr_q + ADDR_STRIDE;
          if (done_q != 8'hFF) done_q <= done_q + 8'd1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef OUTPUT_SEND_SCHED_PERF_EN
  logic [15:0] stall_q, active_q;

  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) begin
      stall_q  <= '0;
      active_q <= '0;
    end else if (LAYER_START && layer_ok) begin
      stall_q  <= '0;
      active_q <= '0;
    end else begin
      if (REQ_VALID && !ready_q && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
      if (state_q != S_IDLE && active_q != 16'hFFFF)
        active_q <= active_q + 16'd1;
    end
  end

  assign PERF_STALL  = stall_q;
  assign PERF_ACTIVE = active_q;
`endif

  assign REQ_READY        = ready_q;
  assign OUTPUT_SEND      = send_q;
  assign OUTPUT_SEND_POOL = send_pool_q;
  assign COUNTER0         = count0_q;
  assign WADDRX_I         = waddr_q;
  assign OUTPUT_EN_CTRL_I = ctrl_q;
  assign SCHED_BUSY       = (state_q != S_IDLE) || (count_q != '0);
  assign DONE_CNT         = done_q;
  assign ERR              = err_q;

endmodule

// File: tb/tb_output_send_sched.sv
// tb/tb_output_send_sched.sv - scoreboard bench for output_send_sched
module tb_output_send_sched;
  logic        CLK = 1'b0;
  logic        RSTL = 1'b0;
  logic        LAYER_START = 1'b0;
  logic [15:0] BASE_ADDR = '0;
  logic [15:0] ADDR_STRIDE = '0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_POOL = 1'b0;
  logic [5:0]  REQ_CTRL = '0;
  logic [7:0]  REQ_COUNT = '0;
  logic        REQ_READY;
  logic        OUTPUT_BUSY;
  logic        OUTPUT_SEND, OUTPUT_SEND_POOL;
  logic [7:0]  COUNTER0;
  logic [15:0] WADDRX_I;
  logic [5:0]  OUTPUT_EN_CTRL_I;
  logic        SCHED_BUSY;
  logic [7:0]  DONE_CNT;
  logic        ERR;
`ifdef OUTPUT_SEND_SCHED_PERF_EN
  logic [15:0] PERF_STALL, PERF_ACTIVE;
`endif

  output_send_sched dut (
    .CLK(CLK), .RSTL(RSTL), .LAYER_START(LAYER_START),
    .BASE_ADDR(BASE_ADDR), .ADDR_STRIDE(ADDR_STRIDE),
    .REQ_VALID(REQ_VALID), .REQ_POOL(REQ_POOL), .REQ_CTRL(REQ_CTRL),
    .REQ_COUNT(REQ_COUNT), .REQ_READY(REQ_READY), .OUTPUT_BUSY(OUTPUT_BUSY),
    .OUTPUT_SEND(OUTPUT_SEND), .OUTPUT_SEND_POOL(OUTPUT_SEND_POOL),
    .COUNTER0(COUNTER0), .WADDRX_I(WADDRX_I), .OUTPUT_EN_CTRL_I(OUTPUT_EN_CTRL_I),
    .SCHED_BUSY(SCHED_BUSY), .DONE_CNT(DONE_CNT), .ERR(ERR)
`ifdef OUTPUT_SEND_SCHED_PERF_EN
    , .PERF_STALL(PERF_STALL), .PERF_ACTIVE(PERF_ACTIVE)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        pool;
    logic [5:0]  ctrl;
    logic [7:0]  cnt;
    logic [15:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_pulses = 0;
  logic        force_busy = 1'b0;
  logic        auto_busy = 1'b0;
  logic        auto_en = 1'b1;
  int          busy_len = 10;
  logic [15:0] next_addr = '0;
  logic [15:0] stride_v = '0;

  assign OUTPUT_BUSY = force_busy | auto_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every start pulse must match the oldest accepted request
  initial forever begin
    exp_t e;
    @(negedge CLK);
    if (OUTPUT_SEND || OUTPUT_SEND_POOL) begin
      n_pulses++;
      chk("pulse_overlap", 32'(OUTPUT_SEND && OUTPUT_SEND_POOL), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_pool", 32'(OUTPUT_SEND_POOL), 32'(e.pool));
        chk("pulse_waddr", 32'(WADDRX_I), 32'(e.addr));
        chk("pulse_ctrl", 32'(OUTPUT_EN_CTRL_I), 32'(e.ctrl));
        chk("pulse_count0", 32'(COUNTER0), 32'(e.cnt));
      end
    end
  end

  // Write-back unit model: busy rises 2 cycles after a start pulse
  initial forever begin
    @(negedge CLK);
    if (auto_en && (OUTPUT_SEND || OUTPUT_SEND_POOL)) begin
      repeat (2) @(posedge CLK);
      #1 auto_busy = 1'b1;
      repeat (busy_len) @(posedge CLK);
      #1 auto_busy = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic layer(input logic [15:0] base, input logic [15:0] stride);
    LAYER_START = 1'b1;
    BASE_ADDR   = base;
    ADDR_STRIDE = stride;
    @(posedge CLK); #1;
    LAYER_START = 1'b0;
    next_addr   = base;
    stride_v    = stride;
  endtask

  task automatic push(input logic pool, input logic [5:0] ctrl, input logic [7:0] cnt,
                      input logic adv);
    logic acc;
    int   cyc;
    acc = 1'b0;
    cyc = 0;
    REQ_VALID = 1'b1; REQ_POOL = pool; REQ_CTRL = ctrl; REQ_COUNT = cnt;
    while (!acc && cyc < 500) begin
      @(negedge CLK);
      acc = REQ_READY;
      @(posedge CLK); #1;
      cyc++;
    end
    REQ_VALID = 1'b0;
    chk("push_accept", 32'(acc), 32'd1);
    if (acc) begin
      exp_q.push_back({pool, ctrl, cnt, next_addr});
      if (adv) next_addr = next_addr + stride_v;
    end
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (SCHED_BUSY && cyc < 5000);
    chk({name, "_idle"}, 32'(SCHED_BUSY), 32'd0);
    chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    int   cyc;
    int   p0;
    logic seen;

    // reset values
    repeat (3) @(negedge CLK);
    chk("rst_ready", 32'(REQ_READY), 32'd0);
    chk("rst_busy", 32'(SCHED_BUSY), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_done", 32'(DONE_CNT), 32'd0);
    chk("rst_waddr", 32'(WADDRX_I), 32'd0);
    chk("rst_send", 32'({OUTPUT_SEND, OUTPUT_SEND_POOL}), 32'd0);
    @(posedge CLK); #1 RSTL = 1'b1;
    @(negedge CLK);
    chk("ready_before_first_clk", 32'(REQ_READY), 32'd0);
    @(negedge CLK);
    chk("ready_after_first_clk", 32'(REQ_READY), 32'd1);
    @(posedge CLK); #1;

    // single request, then one more to expose the advanced base address
    layer(16'h0100, 16'h0040);
    push(1'b0, 6'h15, 8'd7, 1'b1);
    wait_idle("single");
    chk("single_done", 32'(DONE_CNT), 32'd1);
    chk("single_err", 32'(ERR), 32'd0);
    push(1'b1, 6'h2A, 8'd3, 1'b1);
    wait_idle("next_base");
    chk("next_base_done", 32'(DONE_CNT), 32'd2);

    // mixed back-to-back
    layer(16'h0100, 16'h0040);
    push(1'b1, 6'h01, 8'd10, 1'b1);
    push(1'b0, 6'h02, 8'd20, 1'b1);
    push(1'b1, 6'h03, 8'd30, 1'b1);
    wait_idle("mixed");
    chk("mixed_done", 32'(DONE_CNT), 32'd3);

    // FIFO full while the write-back unit is held busy
    layer(16'h0200, 16'h0010);
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(i[0], 6'(i + 1), 8'(i + 40), 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("full_ready_low", 32'(REQ_READY), 32'd0);
    end
    @(posedge CLK); #1;
    force_busy = 1'b0;
    push(1'b1, 6'h3E, 8'd46, 1'b1);
    wait_idle("full");
    chk("full_done", 32'(DONE_CNT), 32'd6);
    chk("full_err", 32'(ERR), 32'd0);

    // acknowledge timeout
    auto_en = 1'b0;
    layer(16'h0300, 16'h0010);
    push(1'b0, 6'h3F, 8'd99, 1'b0);
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 20) begin
      @(negedge CLK);
      seen = OUTPUT_SEND | OUTPUT_SEND_POOL;
      cyc++;
    end
    chk("to_pulse_seen", 32'(seen), 32'd1);
    repeat (15) @(posedge CLK);
    @(negedge CLK);
    chk("to_err_before", 32'(ERR), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    chk("to_err_after", 32'(ERR), 32'd1);
    chk("to_idle", 32'(SCHED_BUSY), 32'd0);
    chk("to_done", 32'(DONE_CNT), 32'd0);
    @(posedge CLK); #1;
    auto_en = 1'b1;
    push(1'b1, 6'h0C, 8'd5, 1'b1);
    wait_idle("to_addr_kept");
    chk("to_done_after", 32'(DONE_CNT), 32'd1);

    // address wrap and DONE_CNT saturation
    busy_len = 1;
    layer(16'hFFE0, 16'h0040);
    for (int i = 0; i < 260; i++) push(i[0], 6'(i), 8'(i), 1'b1);
    wait_idle("wrap");
    chk("sat_done", 32'(DONE_CNT), 32'd255);

    // asynchronous reset in WAIT_DONE with two requests queued
    busy_len = 10;
    auto_en = 1'b0;
    layer(16'h0400, 16'h0010);
    force_busy = 1'b1;
    push(1'b0, 6'h05, 8'd1, 1'b1);
    push(1'b1, 6'h06, 8'd2, 1'b1);
    push(1'b0, 6'h07, 8'd3, 1'b1);
    repeat (3) @(posedge CLK);
    #2;
    chk("pre_reset_busy", 32'(SCHED_BUSY), 32'd1);
    RSTL = 1'b0;
    #1;
    chk("arst_send", 32'({OUTPUT_SEND, OUTPUT_SEND_POOL}), 32'd0);
    chk("arst_count0", 32'(COUNTER0), 32'd0);
    chk("arst_waddr", 32'(WADDRX_I), 32'd0);
    chk("arst_ctrl", 32'(OUTPUT_EN_CTRL_I), 32'd0);
    chk("arst_busy", 32'(SCHED_BUSY), 32'd0);
    chk("arst_done", 32'(DONE_CNT), 32'd0);
    chk("arst_err", 32'(ERR), 32'd0);
    chk("arst_ready", 32'(REQ_READY), 32'd0);
    exp_q.delete();
    force_busy = 1'b0;
    @(posedge CLK); #1 RSTL = 1'b1;
    p0 = n_pulses;
    repeat (30) @(negedge CLK);
    chk("post_rst_pulses", 32'(n_pulses), 32'(p0));
    chk("post_rst_busy", 32'(SCHED_BUSY), 32'd0);
    chk("post_rst_err", 32'(ERR), 32'd0);
    @(posedge CLK); #1;

    // illegal LAYER_START while a request is in flight
    next_addr = 16'h0000;
    force_busy = 1'b1;
    push(1'b0, 6'h11, 8'd1, 1'b1);
    repeat (4) @(posedge CLK);
    #1;
    LAYER_START = 1'b1;
    BASE_ADDR = 16'h5555;
    @(posedge CLK); #1;
    LAYER_START = 1'b0;
    @(negedge CLK);
    chk("illegal_layer_err", 32'(ERR), 32'd1);
    @(posedge CLK); #1;
    force_busy = 1'b0;
    wait_idle("illegal");
    chk("illegal_done", 32'(DONE_CNT), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_send_sched.md
Name: output_send_sched

Overview:
- Scheduler in front of the output write-back unit (the unit that drives WADDRX/WCEBX for pooled and non-pooled layers).
- Queues write-back requests from the compute pipeline and issues them one at a time as OUTPUT_SEND or OUTPUT_SEND_POOL start pulses.
- For each request it supplies the base address, enable control and COUNTER0, then waits out the unit's OUTPUT_BUSY window and advances the write base address by a stride.
- Flags handshake failures.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, 2..16.
- ACK_TIMEOUT, 15, maximum cycles from start pulse to OUTPUT_BUSY rising.

Ports:
- CLK  in  1  clock
- RSTL  in  1  asynchronous reset, active-low
- LAYER_START  in  1  pulse; loads BASE_ADDR and clears DONE_CNT
- BASE_ADDR  in  16  first write address of the layer
- ADDR_STRIDE  in  16  address increment per completed request
- REQ_VALID  in  1  request present
- REQ_POOL  in  1  1 = pooled send, 0 = non-pooled
- REQ_CTRL  in  6  output enable control for the request
- REQ_COUNT  in  8  COUNTER0 value for the request
- REQ_READY  out  1  FIFO can accept a request
- OUTPUT_BUSY  in  1  busy from the write-back unit
- OUTPUT_SEND  out  1  non-pooled start pulse
- OUTPUT_SEND_POOL  out  1  pooled start pulse
- COUNTER0  out  8  held COUNTER0 for the active request
- WADDRX_I  out  16  held base address for the active request
- OUTPUT_EN_CTRL_I  out  6  held control for the active request
- SCHED_BUSY  out  1  FSM not IDLE or FIFO non-empty
- DONE_CNT  out  8  requests completed since LAYER_START; saturates at 255
- ERR  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset values: all outputs 0; FIFO empty; address register 0; FSM in IDLE. REQ_READY is 0 during reset and 1 from the first clock after reset release.
- FIFO:
  - Push when REQ_VALID && REQ_READY. Entry = {REQ_POOL, REQ_CTRL, REQ_COUNT}.
  - REQ_READY = registered count < DEPTH. A same-cycle pop does not re-open READY until the next cycle.
  - Pointers wrap modulo DEPTH.
- Address register:
  - Loaded with BASE_ADDR on LAYER_START, which is accepted only in IDLE with the FIFO empty.
  - LAYER_START at any other time is ignored and sets ERR.
- FSM:
  - IDLE: if FIFO non-empty, pop the head, latch COUNTER0, OUTPUT_EN_CTRL_I and the pool bit, drive WADDRX_I = address register, go to ISSUE.
  - ISSUE (exactly 1 cycle): assert OUTPUT_SEND_POOL if pool else OUTPUT_SEND; the two are never high together. Clear the timeout counter. Go to WAIT_ACK.
  - WAIT_ACK: if OUTPUT_BUSY == 1, go to WAIT_DONE. Otherwise increment the timeout counter; when it reaches ACK_TIMEOUT, set ERR and go to IDLE without advancing the address or DONE_CNT.
  - WAIT_DONE: hold all request outputs stable; on OUTPUT_BUSY == 0 go to ADVANCE.
  - ADVANCE (1 cycle): address += ADDR_STRIDE, modulo 2^16 (wraps silently). DONE_CNT += 1, saturating at 255. Go to IDLE.
- Per-request timing: start pulse 1 cycle after the pop; minimum request period = 4 + busy-window cycles.
- COUNTER0, WADDRX_I and OUTPUT_EN_CTRL_I are stable from ISSUE through ADVANCE. They keep their last values in IDLE.
- Push into an empty FIFO while in IDLE: the pop happens the following cycle; there is no bypass path.
- OUTPUT_BUSY already high in IDLE: ignored; no error.
- Asynchronous reset mid-operation: everything returns to reset values immediately; queued requests are lost.

Optional Feature:
- Macro OUTPUT_SEND_SCHED_PERF_EN.
- Defined:
  - Adds output PERF_STALL (16 bits): counts cycles where REQ_VALID == 1 and REQ_READY == 0.
  - Adds output PERF_ACTIVE (16 bits): counts cycles with the FSM not in IDLE.
  - Both counters clear on LAYER_START and saturate at 0xFFFF.
- Undefined: neither port nor its counter exists; all other behaviour is identical.

Test Plan:
- Single request: LAYER_START with BASE_ADDR=0x0100, STRIDE=0x0040; push {pool=0, ctrl=6'h15, count=8'd7}; bench busy high 2 cycles after the pulse for 10 cycles.
  -> One OUTPUT_SEND pulse with WADDRX_I=0x0100, OUTPUT_EN_CTRL_I=6'h15, COUNTER0=7; DONE_CNT=1; next base address 0x0140; ERR=0.
- Mixed back-to-back: push pool=1, pool=0, pool=1 in consecutive cycles.
  -> Pulses in order SEND_POOL, SEND, SEND_POOL; WADDRX_I = 0x0100, 0x0140, 0x0180; pulses never overlap; DONE_CNT=3.
- FIFO full: hold busy high; push 6 requests with DEPTH=4.
  -> The first request is popped into the FSM, leaving room for a 5th entry; REQ_READY=0 from then until the next pop; the 6th request is not accepted until READY returns; no entry is lost or duplicated.
- Timeout: push one request; keep OUTPUT_BUSY=0.
  -> ERR=1 after 15 cycles in WAIT_ACK; FSM back in IDLE; DONE_CNT and the address unchanged.
- Wrap and saturation: BASE_ADDR=0xFFE0, STRIDE=0x0040, two requests.
  -> WADDRX_I = 0xFFE0 then 0x0020. With 260 requests, DONE_CNT stays at 255.
- Reset mid-operation: drop RSTL while in WAIT_DONE with 2 requests queued.
  -> All outputs 0 immediately; after release SCHED_BUSY=0 and no pulses are issued. An illegal LAYER_START issued afterwards while busy sets ERR.
